screen_fill_engine: RTL and testbench
=====================================

# screen_fill_engine

Parametrised frame-fill engine for the low-resolution pixel framebuffer path. On a `start` request it walks a raster region pixel by pixel and presents one (x, y, colour) write per pixel to the framebuffer writer through a valid/ready handshake. It supports clear-to-black, solid fill, per-row colour stripes and clipped rectangle fill, and reports completion with a one-cycle `done` pulse. It is the next generation of the team's fixed black/colour screen sweeper and sits between the control FSM and the VGA framebuffer write port.

## Interface
Parameters:
- `NX`, 8: x coordinate width.
- `NY`, 7: y coordinate width.
- `WIDTH`, 160: screen width in pixels. Must satisfy WIDTH ≤ 2^NX.
- `HEIGHT`, 120: screen height in pixels. Must satisfy HEIGHT ≤ 2^NY.
- `COLOR_W`, 3: colour width. Must satisfy COLOR_W ≤ NY.

Ports:
- `clk`, in, 1: the single clock. Every register updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: fill request. Sampled only in IDLE.
- `mode`, in, 2: fill mode. 0 = clear, 1 = solid, 2 = stripes, 3 = rectangle.
- `fg_color`, in, COLOR_W: foreground colour. Used by modes 1 and 3.
- `rx0`, `rx1`, in, NX: rectangle x bounds, inclusive.
- `ry0`, `ry1`, in, NY: rectangle y bounds, inclusive.
- `abort`, in, 1: terminates an active fill.
- `plot_ready`, in, 1: the downstream writer accepts the current pixel.
- `plot`, out, 1: a pixel write is valid.
- `x`, out, NX: pixel x coordinate.
- `y`, out, NY: pixel y coordinate.
- `color`, out, COLOR_W: pixel colour.
- `busy`, out, 1: high in DRAW.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- FSM has three states: IDLE, DRAW and DONE. Reset forces IDLE. While `reset` is asserted:
  - `plot`, `busy` and `done` are 0.
  - `x`, `y` and `color` are 0.
  - All latched request fields are 0.
- **IDLE.** When `start` = 1:
  - Latch `mode`, `fg_color` and the rectangle bounds. Later input changes do not affect the fill in progress.
  - Compute the scan region:
    - Modes 0–2: x from 0 to WIDTH-1, y from 0 to HEIGHT-1.
    - Mode 3: x from rx0 to min(rx1, WIDTH-1), y from ry0 to min(ry1, HEIGHT-1).
  - Mode 3 region is empty when rx0 > min(rx1, WIDTH-1) or ry0 > min(ry1, HEIGHT-1). An empty region goes directly to DONE and emits no pixels.
  - A non-empty region goes to DRAW with `x`/`y` loaded with the region start.
- **DRAW.** `plot` = 1 throughout.
  - `x`, `y` and `color` are held stable until `plot_ready` = 1.
  - On `plot_ready` = 1 the pixel is consumed:
    - If x < xmax: x increments.
    - Otherwise x returns to xmin and y increments.
    - If the consumed pixel was (xmax, ymax): go to DONE.
- **Colour** is computed from the next coordinates and registered alongside them:
  - Mode 0: 0.
  - Mode 1: fg_color.
  - Mode 2: y[COLOR_W-1:0].
  - Mode 3: fg_color.
- **Abort.** `abort` = 1 in DRAW goes to DONE on the next edge.
  - If `plot_ready` is also 1 in that cycle, the pixel is counted as written. Abort still wins over advancing.
  - `abort` is ignored in IDLE and DONE.
- **DONE.** `done` = 1 and `plot` = 0 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- **Coordinate arithmetic** is unsigned. Counters never exceed the region bounds, so no wrap-around occurs.

## Timing
- Start to first pixel: `start` sampled at edge N. `plot` = 1 with the first coordinates is visible after edge N. The pipeline is one register deep.
- With `plot_ready` held at 1, throughput is one pixel per clock.
  - Full screen at defaults: 19200 plot cycles.
  - `done` is high in the cycle after the last accepted pixel.
- Back-to-back fills: the earliest new `start` is sampled in the IDLE cycle following DONE. Minimum gap between fills is 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Asserting `reset` mid-fill immediately drops `plot`. After reset deassertion the block sits in IDLE.

## Test plan
- **Mode 0, default parameters, `plot_ready` = 1.**
  - 19200 pixels, first (0,0), last (159,119), all with colour 0.
  - `done` pulses exactly once, one cycle after the last pixel.
- **Mode 2, random `plot_ready` stalls.**
  - Coordinates and colour stay stable while stalled.
  - No pixel is dropped or duplicated.
  - The pixel at row 13 has colour 5.
- **Mode 3, rx0 = 150, rx1 = 200, ry0 = 110, ry1 = 115, fg = 6.**
  - Rectangle is clipped to x 150–159: 60 pixels.
  - Sequence starts (150,110), wraps (159,110) → (150,111), ends (159,115).
- **Mode 3, rx0 = 20, rx1 = 10.** No `plot`. `done` is high 1 cycle after `start`. `busy` stays 0.
- **Abort with simultaneous ready.** In mode 1, assert `abort` together with `plot_ready` at pixel (5,0).
  - Exactly 6 pixels are accepted.
  - `done` follows on the next cycle.
  - A new `start` is accepted 2 cycles after the abort.
- **Reset mid-fill, then restart.** Assert `reset` at pixel (80,60).
  - All outputs go to 0 without waiting for a clock edge.
  - A new mode 1 fill restarts at (0,0).

Source files
------------

// File: rtl/screen_fill_engine_if.sv
// Pixel write port between the fill engine (master) and the framebuffer writer (slave).
// plot/x/y/color travel with plot_ready as a valid/ready pair.
interface screen_fill_engine_if #(
   parameter int NX      = 8,
   parameter int NY      = 7,
   parameter int COLOR_W = 3
);
   logic               plot;
   logic               plot_ready;
   logic [NX-1:0]      x;
   logic [NY-1:0]      y;
   logic [COLOR_W-1:0] color;

   modport master (output plot, x, y, color, input plot_ready);
   modport slave  (input plot, x, y, color, output plot_ready);
endinterface

// File: rtl/screen_fill_engine.sv
// Raster fill engine: walks the full screen or a clipped rectangle and emits one
// (x, y, colour) write per pixel, then pulses done for a single cycle.
module screen_fill_engine #(
   parameter int NX      = 8,
   parameter int NY      = 7,
   parameter int WIDTH   = 160,
   parameter int HEIGHT  = 120,
   parameter int COLOR_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [COLOR_W-1:0] fg_color,
   input  logic [NX-1:0]      rx0,
   input  logic [NX-1:0]      rx1,
   input  logic [NY-1:0]      ry0,
   input  logic [NY-1:0]      ry1,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   screen_fill_engine_if.master pix
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;

   localparam logic [NX-1:0] X_LAST = NX'(WIDTH - 1);
   localparam logic [NY-1:0] Y_LAST = NY'(HEIGHT - 1);

   state_e             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [COLOR_W-1:0] fg_q, fg_d;
   logic [NX-1:0]      xMin_q, xMin_d;
   logic [NX-1:0]      xMax_q, xMax_d;
   logic [NY-1:0]      yMax_q, yMax_d;
   logic [NX-1:0]      x_q, x_d;
   logic [NY-1:0]      y_q, y_d;
   logic [COLOR_W-1:0] color_q, color_d;

   logic               isRect;
   logic               regionEmpty;
   logic [NX-1:0]      xClip, xStart, xEnd;
   logic [NY-1:0]      yClip, yStart, yEnd;

   function automatic logic [COLOR_W-1:0] colorFor(input logic [1:0] m,
                                                    input logic [COLOR_W-1:0] fg,
                                                    input logic [NY-1:0] row);
      logic [COLOR_W-1:0] c;
      case (m)
         2'd0:    c = '0;
         2'd2:    c = row[COLOR_W-1:0];
         default: c = fg;
      endcase
      return c;
   endfunction

   // Region is resolved once at start; the rectangle is clipped to the screen edge.
   assign isRect      = (mode == 2'd3);
   assign xClip       = (rx1 > X_LAST) ? X_LAST : rx1;
   assign yClip       = (ry1 > Y_LAST) ? Y_LAST : ry1;
   assign xStart      = isRect ? rx0   : '0;
   assign yStart      = isRect ? ry0   : '0;
   assign xEnd        = isRect ? xClip : X_LAST;
   assign yEnd        = isRect ? yClip : Y_LAST;
   assign regionEmpty = isRect && ((rx0 > xClip) || (ry0 > yClip));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= '0;
         fg_q    <= '0;
         xMin_q  <= '0;
         xMax_q  <= '0;
         yMax_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         fg_q    <= fg_d;
         xMin_q  <= xMin_d;
         xMax_q  <= xMax_d;
         yMax_q  <= yMax_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      fg_d    = fg_q;
      xMin_d  = xMin_q;
      xMax_d  = xMax_q;
      yMax_d  = yMax_q;
      x_d     = x_q;
      y_d     = y_q;
      color_d = color_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = mode;
               fg_d   = fg_color;
               xMin_d = xStart;
               xMax_d = xEnd;
               yMax_d = yEnd;
               if (regionEmpty) begin
                  state_d = DONE;
               end else begin
                  state_d = DRAW;
                  x_d     = xStart;
                  y_d     = yStart;
                  color_d = colorFor(mode, fg_color, yStart);
               end
            end
         end
         DRAW: begin
            // Abort wins over advancing even when the current pixel is accepted.
            if (abort) begin
               state_d = DONE;
            end else if (pix.plot_ready) begin
               if (x_q < xMax_q) begin
                  x_d = x_q + NX'(1);
               end else if (y_q == yMax_q) begin
                  state_d = DONE;
               end else begin
                  x_d     = xMin_q;
                  y_d     = y_q + NY'(1);
                  color_d = colorFor(mode_q, fg_q, y_q + NY'(1));
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign pix.plot  = (state_q == DRAW);
   assign pix.x     = x_q;
   assign pix.y     = y_q;
   assign pix.color = color_q;
   assign busy      = (state_q == DRAW);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_screen_fill_engine.sv
// Directed bench for screen_fill_engine: expected pixels are queued when a fill is
// requested and popped as the engine hands each accepted pixel to the writer.
module tb_screen_fill_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [1:0] mode;
   logic [2:0] fgColor;
   logic [7:0] rx0, rx1;
   logic [6:0] ry0, ry1;
   logic       busy, done;

   int          testsRun    = 0;
   int          testsFailed = 0;
   logic [31:0] expQ[$];

   int          nAcc;
   logic [31:0] firstPix, lastPix;
   logic        found;

   screen_fill_engine_if #(.NX(8), .NY(7), .COLOR_W(3)) pixIf ();

   screen_fill_engine #(
      .NX(8), .NY(7), .WIDTH(160), .HEIGHT(120), .COLOR_W(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .fg_color (fgColor),
      .rx0      (rx0),
      .rx1      (rx1),
      .ry0      (ry0),
      .ry1      (ry1),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .pix      (pixIf)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pk(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
      return {14'd0, px, py, pc};
   endfunction

   function automatic logic [31:0] curPix();
      return pk(pixIf.x, pixIf.y, pixIf.color);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives a fill request and queues every pixel the request should produce.
   task automatic applyStimulus(input logic [1:0] m, input logic [2:0] fg,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [6:0] b0, input logic [6:0] b1,
                                input int limit, output int expCount);
      int xs, xe, ys, ye;
      logic [2:0] col;
      xs = (m == 2'd3) ? int'(a0) : 0;
      xe = (m == 2'd3) ? ((int'(a1) > 159) ? 159 : int'(a1)) : 159;
      ys = (m == 2'd3) ? int'(b0) : 0;
      ye = (m == 2'd3) ? ((int'(b1) > 119) ? 119 : int'(b1)) : 119;
      expCount = 0;
      for (int yy = ys; yy <= ye; yy++) begin
         for (int xx = xs; xx <= xe; xx++) begin
            if (expCount < limit) begin
               col = (m == 2'd0) ? 3'd0 : ((m == 2'd2) ? 3'(yy) : fg);
               expQ.push_back(pk(8'(xx), 7'(yy), col));
               expCount++;
            end
         end
      end
      start   = 1'b1;
      abort   = 1'b0;
      mode    = m;
      fgColor = fg;
      rx0     = a0;
      rx1     = a1;
      ry0     = b0;
      ry1     = b1;
   endtask

   // Called at a falling edge; returns at the falling edge after the done pulse.
   task automatic runFill(input string tag, input logic [1:0] m, input logic [2:0] fg,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [6:0] b0, input logic [6:0] b1,
                          input int stallPct, input int abortAt,
                          output int accepted, output logic [31:0] firstP, output logic [31:0] lastP);
      int expCount, limit, lastAccept, doneCyc;
      logic held, ready;
      logic [31:0] heldVal, obs, expv;
      limit = (abortAt >= 0) ? abortAt + 1 : 32'h3FFF_FFFF;
      applyStimulus(m, fg, a0, a1, b0, b1, limit, expCount);
      pixIf.plot_ready = 1'b0;
      accepted = 0; lastAccept = 0; doneCyc = -1;
      held = 1'b0; heldVal = '0; firstP = '1; lastP = '1;
      @(negedge clk);
      start = 1'b0; mode = ~m; fgColor = ~fg;
      rx0 = ~a0; rx1 = ~a1; ry0 = ~b0; ry1 = ~b1;
      for (int c = 1; c <= 30000; c++) begin
         if (done === 1'b1) begin
            doneCyc = c;
            break;
         end
         checkOutput({tag, " plot active"}, {31'd0, pixIf.plot}, {31'd0, expCount > 0});
         checkOutput({tag, " busy active"}, {31'd0, busy}, {31'd0, expCount > 0});
         if (held) checkOutput({tag, " stall hold"}, curPix(), heldVal);
         if (pixIf.plot === 1'b1) begin
            ready = ($urandom_range(99) >= stallPct);
            pixIf.plot_ready = ready;
            if (ready) begin
               obs = curPix();
               if (expQ.size() == 0) begin
                  checkOutput({tag, " extra pixel"}, obs, 32'hFFFF_FFFF);
               end else begin
                  expv = expQ.pop_front();
                  checkOutput({tag, " pixel"}, obs, expv);
               end
               if (accepted == 0) firstP = obs;
               lastP = obs;
               accepted++;
               lastAccept = c;
               if (m == 2'd2 && pixIf.x == 8'd0 && pixIf.y == 7'd13)
                  checkOutput({tag, " row13 colour"}, {29'd0, pixIf.color}, 32'd5);
               if (accepted == abortAt + 1) abort = 1'b1;
            end
            held    = !ready;
            heldVal = curPix();
         end else begin
            pixIf.plot_ready = 1'b0;
            held = 1'b0;
         end
         @(negedge clk);
         abort = 1'b0;
      end
      if (doneCyc < 0) begin
         checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
      end else begin
         checkOutput({tag, " done latency"}, doneCyc, lastAccept + 1);
         checkOutput({tag, " plot low in done"}, {31'd0, pixIf.plot}, 32'd0);
         checkOutput({tag, " busy low in done"}, {31'd0, busy}, 32'd0);
         @(negedge clk);
         checkOutput({tag, " done one cycle"}, {31'd0, done}, 32'd0);
         checkOutput({tag, " idle after done"}, {31'd0, busy}, 32'd0);
      end
      checkOutput({tag, " pixel count"}, accepted, expCount);
      expQ.delete();
      pixIf.plot_ready = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; fgColor = 3'd0;
      rx0 = '0; rx1 = '0; ry0 = '0; ry1 = '0;
      pixIf.plot_ready = 1'b0;
      #2;
      checkOutput("reset plot", {31'd0, pixIf.plot}, 32'd0);
      checkOutput("reset busy/done", {30'd0, busy, done}, 32'd0);
      checkOutput("reset pixel", curPix(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle after reset", {30'd0, pixIf.plot, done}, 32'd0);

      runFill("clear", 2'd0, 3'd5, 8'd0, 8'd0, 7'd0, 7'd0, 0, -1, nAcc, firstPix, lastPix);
      checkOutput("clear total", nAcc, 32'd19200);
      checkOutput("clear first", firstPix, pk(8'd0, 7'd0, 3'd0));
      checkOutput("clear last", lastPix, pk(8'd159, 7'd119, 3'd0));

      runFill("stripes", 2'd2, 3'd1, 8'd0, 8'd0, 7'd0, 7'd0, 20, -1, nAcc, firstPix, lastPix);
      checkOutput("stripes last", lastPix, pk(8'd159, 7'd119, 3'd7));

      runFill("rect clip", 2'd3, 3'd6, 8'd150, 8'd200, 7'd110, 7'd115, 10, -1, nAcc, firstPix, lastPix);
      checkOutput("rect clip total", nAcc, 32'd60);
      checkOutput("rect clip first", firstPix, pk(8'd150, 7'd110, 3'd6));
      checkOutput("rect clip last", lastPix, pk(8'd159, 7'd115, 3'd6));

      runFill("rect empty", 2'd3, 3'd6, 8'd20, 8'd10, 7'd0, 7'd5, 0, -1, nAcc, firstPix, lastPix);
      checkOutput("rect empty total", nAcc, 32'd0);

      runFill("abort", 2'd1, 3'd4, 8'd0, 8'd0, 7'd0, 7'd0, 0, 5, nAcc, firstPix, lastPix);
      checkOutput("abort total", nAcc, 32'd6);
      checkOutput("abort last", lastPix, pk(8'd5, 7'd0, 3'd4));
      runFill("after abort", 2'd3, 3'd2, 8'd0, 8'd3, 7'd0, 7'd1, 0, -1, nAcc, firstPix, lastPix);
      checkOutput("after abort first", firstPix, pk(8'd0, 7'd0, 3'd2));

      start = 1'b1; mode = 2'd1; fgColor = 3'd4; pixIf.plot_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 12000; c++) begin
         if (pixIf.plot === 1'b1 && pixIf.x == 8'd80 && pixIf.y == 7'd60) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("reset target reached", {31'd0, found}, 32'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("mid-fill reset plot", {31'd0, pixIf.plot}, 32'd0);
      checkOutput("mid-fill reset busy/done", {30'd0, busy, done}, 32'd0);
      checkOutput("mid-fill reset pixel", curPix(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      pixIf.plot_ready = 1'b0;
      @(negedge clk);
      checkOutput("idle after mid-fill reset", {30'd0, pixIf.plot, busy}, 32'd0);

      runFill("restart", 2'd1, 3'd3, 8'd0, 8'd0, 7'd0, 7'd0, 0, 20, nAcc, firstPix, lastPix);
      checkOutput("restart first", firstPix, pk(8'd0, 7'd0, 3'd3));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
